// File: rtl/mc_pkg.sv
// mc_pkg: shared state type, datapath select encodings and instruction decode helper
// for the multicycle ARM-subset controller.
package mc_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_t;
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   // flag_w[1] enables the N/Z update, flag_w[0] the C/V update
   typedef struct packed {
      logic [1:0] alu_control;
      logic [1:0] flag_w;
      logic       no_write;
   } aludec_t;
   // Unknown commands execute as ADD; CMP sets flags even without the S bit
   function automatic aludec_t alu_decode(input logic [3:0] cmd, input logic s);
      aludec_t d;
      d.no_write    = cmd == CMD_CMP;
      d.alu_control = (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
                      cmd == CMD_AND ? ALU_AND :
                      cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
      d.flag_w      = !(s || d.no_write) ? 2'b00 :
                      (d.alu_control == ALU_AND || d.alu_control == ALU_ORR) ? 2'b10 : 2'b11;
      return d;
   endfunction
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction fields and ALU flags into the controller, datapath controls out.
//  master: controller side (cond/op/funct/rd/alu_flags in; enables, selects, flags out)
//  slave : datapath side (mirror image)
interface mc_controller_if;
   import mc_pkg::*;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       pc_write;
   logic       mem_write;
   logic       reg_write;
   logic       ir_write;
   logic       adr_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_control;
   logic [3:0] flags;
   modport master (
      input  cond, op, funct, rd, alu_flags,
      output pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
             alu_src_b, result_src, alu_control, flags
   );
   modport slave (
      output cond, op, funct, rd, alu_flags,
      input  pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
             alu_src_b, result_src, alu_control, flags
   );
endinterface

// File: rtl/mc_controller_condcheck.sv
// condcheck: evaluates an ARM condition code against {N,Z,C,V}.
//  cond in 4, flags in 4, condex out 1
module condcheck (
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condex
);
   logic n, z, c, v;
   logic [7:0] base;
   assign {n, z, c, v} = flags;
   // Codes come in true/inverted pairs; bit 0 selects the inverse (1111 = never)
   assign base   = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
   assign condex = base[cond[3:1]] ^ cond[0];
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control unit with NZCV flag register.
//  clk   in  rising-edge clock
//  reset in  asynchronous active-low reset
//  bus   mc_controller_if.master: instruction fields/ALU flags in, datapath controls out
module mc_controller
   import mc_pkg::*;
#(
   parameter logic [3:0] PC_REG = 4'd15
) (
   input logic            clk,
   input logic            reset,
   mc_controller_if.master bus
);
   state_t     state, next;
   logic [3:0] flags_q;
   logic       condex;
   logic       is_exec;
   aludec_t    dec;
   condcheck u_cond (.cond(bus.cond), .flags(flags_q), .condex(condex));
   assign dec       = alu_decode(bus.funct[4:1], bus.funct[0]);
   assign is_exec   = state == S_EXECR || state == S_EXECI;
   assign bus.flags = flags_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= S_FETCH;
      else state <= next;
   // Flags update when leaving execute; condex still sees the old value this cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) flags_q <= 4'b0000;
      else begin
         if (is_exec && condex && dec.flag_w[1]) flags_q[3:2] <= bus.alu_flags[3:2];
         if (is_exec && condex && dec.flag_w[0]) flags_q[1:0] <= bus.alu_flags[1:0];
      end
   // Outputs are forced low directly by reset so no enable can pulse on assertion
   always_comb begin
      next            = S_FETCH;
      bus.pc_write    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.reg_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.adr_src     = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = SRCB_RD2;
      bus.result_src  = RES_ALUOUT;
      bus.alu_control = ALU_ADD;
      if (reset)
         case (state)
            S_FETCH: begin
               next           = S_DECODE;
               bus.ir_write   = 1'b1;
               bus.pc_write   = 1'b1;
               bus.alu_src_a  = 1'b1;
               bus.alu_src_b  = SRCB_FOUR;
               bus.result_src = RES_ALU;
            end
            S_DECODE: begin
               next           = bus.op == OP_MEM ? S_MEMADR :
                                bus.op == OP_BR  ? S_BRANCH :
                                bus.op == OP_DP  ? (bus.funct[5] ? S_EXECI : S_EXECR) : S_FETCH;
               bus.alu_src_a  = 1'b1;
               bus.alu_src_b  = SRCB_FOUR;
               bus.result_src = RES_ALU;
            end
            S_MEMADR: begin
               next          = bus.funct[0] ? S_MEMRD : S_MEMWR;
               bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
               next        = S_MEMWB;
               bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
               bus.reg_write  = condex;
               bus.result_src = RES_DATA;
            end
            S_MEMWR: begin
               bus.mem_write = condex;
               bus.adr_src   = 1'b1;
            end
            S_EXECR, S_EXECI: begin
               next            = S_ALUWB;
               bus.alu_src_b   = state == S_EXECI ? SRCB_IMM : SRCB_RD2;
               bus.alu_control = dec.alu_control;
            end
            S_ALUWB: begin
               bus.reg_write = condex & ~dec.no_write;
               bus.pc_write  = condex & (bus.rd == PC_REG);
            end
            S_BRANCH: begin
               bus.pc_write   = condex;
               bus.alu_src_b  = SRCB_IMM;
               bus.result_src = RES_ALU;
            end
            default: ;
         endcase
   end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller
module tb_mc_controller;
   typedef struct {
      string       tag;
      logic [15:0] exp;
      logic [15:0] msk;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [3:0] fl = 4'b0000;
   exp_t sb[$];
   mc_controller_if bus ();
   mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   // {pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_control, flags}
   function automatic logic [15:0] obs();
      return {bus.pc_write, bus.mem_write, bus.reg_write, bus.ir_write, bus.adr_src, bus.alu_src_a,
              bus.alu_src_b, bus.result_src, bus.alu_control, bus.flags};
   endfunction
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'ha: return n == v;
         4'hb: return n != v;
         4'hc: return !z && n == v;
         4'hd: return z || n != v;
         4'he: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   // en = {pc_write, mem_write, reg_write, ir_write}; f/m = {adr, srca, srcb[1:0], res[1:0], aluc[1:0]}
   task automatic push(input string tag, input logic [3:0] en, input logic [7:0] f, input logic [7:0] m);
      exp_t e;
      e.tag = tag;
      e.exp = {en, f, fl};
      e.msk = {4'hf, m, 4'hf};
      sb.push_back(e);
   endtask
   task automatic instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                        input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af);
      logic ce, nw;
      logic [1:0] ac;
      exp_t e;
      bus.cond = c;
      bus.op = op;
      bus.funct = fn;
      bus.rd = rd;
      bus.alu_flags = af;
      ce = cond_ok(c, fl);
      push({tag, ":fetch"}, 4'b1001, 8'h00, 8'h80);
      push({tag, ":decode"}, 4'b0000, 8'h00, 8'h00);
      if (op == 2'b10) push({tag, ":branch"}, {ce, 3'b000}, 8'h10, 8'h33);
      else if (op == 2'b01) begin
         push({tag, ":memadr"}, 4'b0000, 8'h10, 8'h33);
         if (fn[0]) begin
            push({tag, ":memrd"}, 4'b0000, 8'h80, 8'h80);
            push({tag, ":memwb"}, {2'b00, ce, 1'b0}, 8'h04, 8'h0c);
         end else push({tag, ":memwr"}, {1'b0, ce, 2'b00}, 8'h80, 8'h80);
      end else if (op == 2'b00) begin
         nw = fn[4:1] == 4'b1010;
         case (fn[4:1])
            4'b0010, 4'b1010: ac = 2'b01;
            4'b0000: ac = 2'b10;
            4'b1100: ac = 2'b11;
            default: ac = 2'b00;
         endcase
         push({tag, ":exec"}, 4'b0000, {2'b00, 1'b0, fn[5], 2'b00, ac}, 8'h33);
         if (ce && (fn[0] || nw)) fl = ac[1] ? {af[3:2], fl[1:0]} : af;
         push({tag, ":aluwb"}, {ce && rd == 4'd15, 1'b0, ce && !nw, 1'b0}, 8'h00, 8'h00);
      end
      repeat (sb.size()) begin
         @(negedge clk);
         e = sb.pop_front();
         check(e.tag, obs() & e.msk, e.exp);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.cond = 4'h0;
      bus.op = 2'b00;
      bus.funct = 6'b0;
      bus.rd = 4'h0;
      bus.alu_flags = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", obs(), 16'h0000);
      @(posedge clk);
      #1 reset = 1'b1;
      instr("add_imm", 4'he, 2'b00, 6'b001000, 4'd1, 4'hf);
      instr("subs", 4'he, 2'b00, 6'b000101, 4'd0, 4'b0100);
      instr("beq_taken", 4'h0, 2'b10, 6'b0, 4'd0, 4'h0);
      bus.cond = 4'he;
      bus.op = 2'b01;
      bus.funct = 6'b011001;
      bus.rd = 4'd2;
      @(negedge clk);
      check("rst:fetch", obs() & 16'hf00f, {4'b1001, 8'h00, fl});
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst:decode", obs() & 16'hf00f, {4'b0000, 8'h00, fl});
      #1 reset = 1'b0;
      #1 check("rst:assert", obs(), 16'h0000);
      fl = 4'b0000;
      @(posedge clk);
      #1 check("rst:hold", obs(), 16'h0000);
      reset = 1'b1;
      instr("beq_not", 4'h0, 2'b10, 6'b0, 4'd0, 4'h0);
      instr("bne_taken", 4'h1, 2'b10, 6'b0, 4'd0, 4'h0);
      instr("ldr", 4'he, 2'b01, 6'b011001, 4'd2, 4'h0);
      instr("str", 4'he, 2'b01, 6'b011000, 4'd3, 4'h0);
      instr("str_never", 4'hf, 2'b01, 6'b011000, 4'd3, 4'h0);
      instr("cmp", 4'he, 2'b00, 6'b010101, 4'd0, 4'b0110);
      instr("mov_pc_ne", 4'h1, 2'b00, 6'b011010, 4'd15, 4'hf);
      instr("add_pc", 4'he, 2'b00, 6'b001000, 4'd15, 4'h0);
      instr("ands", 4'he, 2'b00, 6'b000001, 4'd4, 4'b1001);
      instr("orr_reg", 4'he, 2'b00, 6'b011000, 4'd5, 4'h0);
      instr("subs_skip", 4'h0, 2'b00, 6'b000101, 4'd6, 4'b0101);
      instr("op11", 4'he, 2'b11, 6'b0, 4'd0, 4'h0);
      instr("b_always", 4'he, 2'b10, 6'b0, 4'd0, 4'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
